// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arith_pkg
//  Description : Shared types, opcodes and helpers for the arithmetic library.
//                Provides the sequencer state enum, the add/subtract opcode
//                constants and a constant-evaluable ceil(log2) helper.
//  Revision    : 1.0  initial release
// ============================================================================
package arith_pkg;

    // Sequencer states shared by the multi-cycle arithmetic units.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // control_in encodings.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Ceiling log2, usable in constant expressions.
    // Returns at least 1 so a counter for value=1 still has one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_addsub_full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Single-bit full-adder cell (pure combinational).
//  Ports       : a_in, b_in, c_in     - addend bits and carry in
//                sum_out, carry_out   - sum bit and carry out
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic sum_out,
    output logic carry_out
);

    assign sum_out   = a_in ^ b_in ^ c_in;
    assign carry_out = (a_in & b_in) | (c_in & (a_in ^ b_in));

endmodule
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub
//  Description : Bit-serial WIDTH-bit two's-complement adder/subtractor.
//                One bit per clock, LSB first, through one full-adder cell
//                with a registered carry. start/busy/done handshake.
//  Ports       : clk_in        - clock, rising edge
//                rst_n_in      - synchronous active-low reset
//                start_in      - request, accepted in IDLE or DONE
//                a_in, b_in    - operands, sampled on the accepting edge
//                control_in    - 0 add, 1 subtract
//                busy_out      - high while bits are being processed
//                done_out      - one-cycle completion pulse
//                result_out    - A +/- B mod 2^WIDTH, held until next done
//                carry_out     - MSB carry out (subtract: 1 = no borrow)
//                overflow_out  - signed overflow
//  Revision    : 1.0  initial release
// ============================================================================
module serial_addsub
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             control_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out,
    output logic             carry_out,
    output logic             overflow_out
);

    localparam int                c_cnt_w    = clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    // Carry out of bit WIDTH-2 is the carry into the MSB.
    localparam logic [c_cnt_w-1:0] c_cnt_pre  = c_cnt_w'(WIDTH - 2);

    state_t             r_state_q,    r_state_d;
    logic [c_cnt_w-1:0] r_cnt_q,      r_cnt_d;
    logic               r_carry_q,    r_carry_d;
    logic               r_c_msb_q,    r_c_msb_d;
    logic [WIDTH-1:0]   r_opa_q,      r_opa_d;
    logic [WIDTH-1:0]   r_opb_q,      r_opb_d;
    logic [WIDTH-1:0]   r_acc_q,      r_acc_d;
    logic               r_busy_q,     r_busy_d;
    logic               r_done_q,     r_done_d;
    logic [WIDTH-1:0]   r_result_q,   r_result_d;
    logic               r_cout_q,     r_cout_d;
    logic               r_ovf_q,      r_ovf_d;

    logic w_sum;
    logic w_cout;

    full_adder u_full_adder (
        .a_in      (r_opa_q[0]),
        .b_in      (r_opb_q[0]),
        .c_in      (r_carry_q),
        .sum_out   (w_sum),
        .carry_out (w_cout)
    );

    always_comb begin
        r_state_d  = r_state_q;
        r_cnt_d    = r_cnt_q;
        r_carry_d  = r_carry_q;
        r_c_msb_d  = r_c_msb_q;
        r_opa_d    = r_opa_q;
        r_opb_d    = r_opb_q;
        r_acc_d    = r_acc_q;
        r_busy_d   = 1'b0;
        r_done_d   = 1'b0;
        r_result_d = r_result_q;
        r_cout_d   = r_cout_q;
        r_ovf_d    = r_ovf_q;

        case (r_state_q)
            IDLE, DONE: begin
                if (start_in) begin
                    // Subtract as A + ~B + 1: invert B here, +1 via carry.
                    r_opa_d   = a_in;
                    r_opb_d   = b_in ^ {WIDTH{control_in}};
                    r_carry_d = control_in;
                    r_cnt_d   = '0;
                    r_busy_d  = 1'b1;
                    r_state_d = RUN;
                end else begin
                    r_state_d = IDLE;
                end
            end
            RUN: begin
                r_opa_d   = {1'b0, r_opa_q[WIDTH-1:1]};
                r_opb_d   = {1'b0, r_opb_q[WIDTH-1:1]};
                r_acc_d   = {w_sum, r_acc_q[WIDTH-1:1]};
                r_carry_d = w_cout;
                r_cnt_d   = r_cnt_q + c_cnt_w'(1);
                if (r_cnt_q == c_cnt_pre) begin
                    r_c_msb_d = w_cout;
                end
                if (r_cnt_q == c_cnt_last) begin
                    r_state_d  = DONE;
                    r_done_d   = 1'b1;
                    r_result_d = {w_sum, r_acc_q[WIDTH-1:1]};
                    r_cout_d   = w_cout;
                    r_ovf_d    = r_c_msb_q ^ w_cout;
                end else begin
                    r_busy_d   = 1'b1;
                end
            end
            default: begin
                r_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state_q  <= IDLE;
            r_cnt_q    <= '0;
            r_carry_q  <= 1'b0;
            r_c_msb_q  <= 1'b0;
            r_opa_q    <= '0;
            r_opb_q    <= '0;
            r_acc_q    <= '0;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
            r_result_q <= '0;
            r_cout_q   <= 1'b0;
            r_ovf_q    <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            r_cnt_q    <= r_cnt_d;
            r_carry_q  <= r_carry_d;
            r_c_msb_q  <= r_c_msb_d;
            r_opa_q    <= r_opa_d;
            r_opb_q    <= r_opb_d;
            r_acc_q    <= r_acc_d;
            r_busy_q   <= r_busy_d;
            r_done_q   <= r_done_d;
            r_result_q <= r_result_d;
            r_cout_q   <= r_cout_d;
            r_ovf_q    <= r_ovf_d;
        end
    end

    assign busy_out     = r_busy_q;
    assign done_out     = r_done_q;
    assign result_out   = r_result_q;
    assign carry_out    = r_cout_q;
    assign overflow_out = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_addsub
//  Description : Directed self-checking bench for serial_addsub (WIDTH=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_addsub;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ctrl;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] prev_result = '0;
    logic             prev_cout   = 1'b0;
    logic             prev_ovf    = 1'b0;

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .start_in     (start),
        .a_in         (a),
        .b_in         (b),
        .control_in   (ctrl),
        .busy_out     (busy),
        .done_out     (done),
        .result_out   (result),
        .carry_out    (cout),
        .overflow_out (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full operation from idle: accept, 7 running edges, completion edge.
    task automatic run_op(input string name, input logic [WIDTH-1:0] opa,
                          input logic [WIDTH-1:0] opb, input logic op,
                          input logic [WIDTH-1:0] exp_res, input logic exp_c,
                          input logic exp_v);
        start = 1'b1; a = opa; b = opb; ctrl = op;
        step();                                   // E0: accept
        start = 1'b0; a = ~opa; b = ~opb; ctrl = ~op;
        check({name, " busy@E0"}, {31'b0, busy}, 32'd1);
        check({name, " done@E0"}, {31'b0, done}, 32'd0);
        for (int i = 1; i < WIDTH; i++) step();   // E1..E7
        check({name, " busy@E7"}, {31'b0, busy}, 32'd1);
        check({name, " held result@E7"}, {24'b0, result}, {24'b0, prev_result});
        check({name, " held cv@E7"}, {30'b0, cout, ovf}, {30'b0, prev_cout, prev_ovf});
        step();                                   // E8: completion
        check({name, " done"}, {31'b0, done}, 32'd1);
        check({name, " busy@done"}, {31'b0, busy}, 32'd0);
        check({name, " result"}, {24'b0, result}, {24'b0, exp_res});
        check({name, " carry"}, {31'b0, cout}, {31'b0, exp_c});
        check({name, " overflow"}, {31'b0, ovf}, {31'b0, exp_v});
        step();                                   // back to IDLE
        check({name, " done pulse width"}, {31'b0, done}, 32'd0);
        prev_result = exp_res; prev_cout = exp_c; prev_ovf = exp_v;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; ctrl = 1'b0;
        step();
        step();
        check("reset outputs", {20'b0, busy, done, result, cout, ovf}, 32'd0);
        rst_n = 1'b1;
        step();

        run_op("add 100+27", 8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0);
        run_op("add 200+100", 8'd200, 8'd100, 1'b0, 8'h2C, 1'b1, 1'b0);
        run_op("add 127+1", 8'd127, 8'd1, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("sub 5-7", 8'd5, 8'd7, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("sub 80-1", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_op("sub 9-9", 8'd9, 8'd9, 1'b1, 8'h00, 1'b1, 1'b0);

        // start held high through RUN; new operands must not disturb it.
        start = 1'b1; a = 8'd100; b = 8'd27; ctrl = 1'b0;
        step();                                   // E0 accept
        a = 8'd5; b = 8'd7; ctrl = 1'b1;          // next op, start stays high
        for (int i = 1; i < WIDTH; i++) step();
        check("hold start no early done", {31'b0, done}, 32'd0);
        step();                                   // E8: first done
        check("b2b first done", {31'b0, done}, 32'd1);
        check("b2b first result", {24'b0, result}, 32'd127);
        step();                                   // accept in DONE
        start = 1'b0;
        check("b2b accepted busy", {31'b0, busy}, 32'd1);
        check("b2b done cleared", {31'b0, done}, 32'd0);
        for (int i = 1; i < WIDTH; i++) step();
        check("b2b no done at 7", {31'b0, done}, 32'd0);
        step();
        check("b2b second done at 8", {31'b0, done}, 32'd1);
        check("b2b second result", {24'b0, result}, 32'hFE);
        check("b2b second carry", {31'b0, cout}, 32'd0);
        step();

        // Reset mid-run (after bits 0..3 processed).
        start = 1'b1; a = 8'd200; b = 8'd100; ctrl = 1'b0;
        step();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) step();
        rst_n = 1'b0;
        step();
        check("abort outputs zero", {20'b0, busy, done, result, cout, ovf}, 32'd0);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                step();
                if (done || busy) seen++;
            end
            check("abort no done/busy", seen, 32'd0);
        end
        check("abort result stays zero", {24'b0, result}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
